tm1638_key_reader: RTL and testbench

- Reader side of the TM1638 serial interface. The display path writes segment bytes to the chip; this block issues the key-scan read command (0x42) and shifts in the chip's 4-byte key matrix.
- Outputs both the raw 32-bit scan word and an 8-key decoded vector.
- Sits beside the display writer under the TM1638 top. The parent muxes STB/CLK/DIO to whichever block is busy.

---
 rtl/tm1638_key_reader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader
// Reads the TM1638 key matrix. On a start request it lowers STB, sends the
// key-scan command byte 0x42 LSB first, releases DIO for the chip's turnaround
// wait, clocks in 32 bits (LSB of byte0 first), then holds STB low for one
// more phase before returning the bus to idle.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   start         request one scan (sampled only while idle)
//   busy          transaction owns the bus
//   done          one-cycle pulse when raw/keys have been updated
//   raw[31:0]     scan word, byte0 in [7:0]
//   keys[7:0]     keys[k] = raw[8k], keys[k+4] = raw[8k+4]
//   tm_stb        STB, active low
//   tm_clk        serial clock, idles high
//   tm_dio_o/oe   DIO drive value / drive enable (0 = released)
//   tm_dio_i      DIO pad input, already synchronised
//
// Optional build macro: TM_KEY_DEBOUNCE_EN
//   When defined, keys only loads a new decode when two consecutive scan
//   words are identical. raw always updates.
//
// All bus outputs are flops whose next values are decoded from the next
// state, so each output changes on the same edge as the state it belongs to.

module tm1638_key_reader #(
  parameter int CLK_DIV     = 100,
  parameter int WAIT_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] raw,
  output logic [7:0]  keys,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio_o,
  output logic        tm_dio_oe,
  input  logic        tm_dio_i
);

  localparam int CNT_MAX = (CLK_DIV > WAIT_CYCLES) ? CLK_DIV : WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [7:0]       CMD_READ  = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CMD   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Key decode: bits 0 and 4 of each scan byte carry the two keys of a column.
  function automatic logic [7:0] decode_keys(input logic [31:0] w);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = w[8*i];
      k[i + 4] = w[8*i + 4];
    end
    return k;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d;      // 0 = low half of a bit, 1 = high half
  logic [4:0]       bit_q, bit_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      raw_q, raw_d;
  logic [7:0]       keys_q, keys_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic             sclk_q, sclk_d;
  logic             dio_o_q, dio_o_d;
  logic             dio_oe_q, dio_oe_d;
  logic             last_phase_s;
`ifdef TM_KEY_DEBOUNCE_EN
  logic [31:0]      shadow_q, shadow_d;
`endif

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    hi_d     = hi_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    raw_d    = raw_q;
    keys_d   = keys_q;
    done_d   = 1'b0;
`ifdef TM_KEY_DEBOUNCE_EN
    shadow_d = shadow_q;
`endif
    last_phase_s = (cnt_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_SETUP;
          hi_d    = 1'b0;
          bit_d   = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (last_phase_s) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          hi_d    = 1'b0;
          bit_d   = 5'd0;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_CMD: begin
        if (last_phase_s) begin
          cnt_d = '0;
          if (!hi_q) begin
            hi_d = 1'b1;
          end else if (bit_q == 5'd7) begin
            state_d = ST_WAIT;
            hi_d    = 1'b0;
            bit_d   = 5'd0;
          end else begin
            hi_d  = 1'b0;
            bit_d = bit_q + 5'd1;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_READ;
          cnt_d   = '0;
          hi_d    = 1'b0;
          bit_d   = 5'd0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_READ: begin
        if (last_phase_s) begin
          cnt_d = '0;
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            // Sample at the very end of the high phase, just before CLK falls.
            shift_d[bit_q] = tm_dio_i;
            hi_d           = 1'b0;
            if (bit_q == 5'd31) begin
              state_d = ST_HOLD;
              bit_d   = 5'd0;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_HOLD: begin
        if (last_phase_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          raw_d   = shift_q;
`ifdef TM_KEY_DEBOUNCE_EN
          shadow_d = shift_q;
          if (shift_q == shadow_q) begin
            keys_d = decode_keys(shift_q);
          end else begin
            keys_d = keys_q;
          end
`else
          keys_d = decode_keys(shift_q);
`endif
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE: begin
        stb_d = 1'b1; sclk_d = 1'b1; dio_o_d = 1'b0; dio_oe_d = 1'b0;
      end
      ST_SETUP: begin
        stb_d = 1'b0; sclk_d = 1'b1; dio_o_d = CMD_READ[0]; dio_oe_d = 1'b1;
      end
      ST_CMD: begin
        stb_d = 1'b0; sclk_d = hi_d; dio_o_d = CMD_READ[bit_d[2:0]]; dio_oe_d = 1'b1;
      end
      ST_READ: begin
        stb_d = 1'b0; sclk_d = hi_d; dio_o_d = 1'b0; dio_oe_d = 1'b0;
      end
      ST_WAIT, ST_HOLD: begin
        stb_d = 1'b0; sclk_d = 1'b1; dio_o_d = 1'b0; dio_oe_d = 1'b0;
      end
      default: begin
        stb_d = 1'b1; sclk_d = 1'b1; dio_o_d = 1'b0; dio_oe_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      bit_q    <= 5'd0;
      shift_q  <= 32'd0;
      raw_q    <= 32'd0;
      keys_q   <= 8'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      stb_q    <= 1'b1;
      sclk_q   <= 1'b1;
      dio_o_q  <= 1'b0;
      dio_oe_q <= 1'b0;
`ifdef TM_KEY_DEBOUNCE_EN
      shadow_q <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      raw_q    <= raw_d;
      keys_q   <= keys_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      stb_q    <= stb_d;
      sclk_q   <= sclk_d;
      dio_o_q  <= dio_o_d;
      dio_oe_q <= dio_oe_d;
`ifdef TM_KEY_DEBOUNCE_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign raw       = raw_q;
  assign keys      = keys_q;
  assign tm_stb    = stb_q;
  assign tm_clk    = sclk_q;
  assign tm_dio_o  = dio_o_q;
  assign tm_dio_oe = dio_oe_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader
// Directed bench for tm1638_key_reader with CLK_DIV=4, WAIT_CYCLES=8.
// A small chip model captures the command bits on CLK rising edges while
// DIO is driven, and presents scan-word bit n after the (9+n)-th CLK fall.
// Expected keys values are hand-decoded from each scan word; they differ
// between the plain and the TM_KEY_DEBOUNCE_EN build.

module tb_tm1638_key_reader;

  localparam int K = 4;
  localparam int W = 8;
  localparam int LAT = 1 + 82 * K + W;  // 337
  localparam int CMD_END = 17 * K;      // last cycle of SETUP+CMD after STB falls

  localparam logic [31:0] WORD_A = 32'h1100_1001;
  // WORD_A: byte0=0x01 -> key0, byte1=0x10 -> key5, byte3=0x11 -> key3,key7
`ifdef TM_KEY_DEBOUNCE_EN
  localparam logic [7:0] EK1 = 8'h00;
  localparam logic [7:0] EK2 = 8'hA9;
  localparam logic [7:0] EK3 = 8'hA9;
  localparam logic [7:0] EK4 = 8'hA9;
  localparam logic [7:0] EK5 = 8'h10;
  localparam logic [7:0] EK6 = 8'h00;
`else
  localparam logic [7:0] EK1 = 8'hA9;
  localparam logic [7:0] EK2 = 8'hA9;
  localparam logic [7:0] EK3 = 8'h01;
  localparam logic [7:0] EK4 = 8'h10;
  localparam logic [7:0] EK5 = 8'h10;
  localparam logic [7:0] EK6 = 8'hA9;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] raw;
  logic [7:0]  keys;
  logic        tm_stb;
  logic        tm_clk;
  logic        tm_dio_o;
  logic        tm_dio_oe;
  logic        tm_dio_i;

  int checks = 0;
  int errors = 0;

  // chip model / bus monitor state
  logic [31:0] chip_word = 32'd0;
  logic [7:0]  cmd_byte  = 8'd0;
  int          cmd_n     = 0;
  int          oe_bad    = 0;
  int          fcnt      = 0;
  int          scnt      = 0;
  logic        prev_clk  = 1'b1;

  tm1638_key_reader #(.CLK_DIV(K), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .raw       (raw),
    .keys      (keys),
    .tm_stb    (tm_stb),
    .tm_clk    (tm_clk),
    .tm_dio_o  (tm_dio_o),
    .tm_dio_oe (tm_dio_oe),
    .tm_dio_i  (tm_dio_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Chip model and bus monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (tm_stb) begin
      fcnt = 0;
      scnt = 0;
      if (tm_dio_oe) oe_bad++;
    end else begin
      scnt++;
      if (prev_clk && !tm_clk) begin
        fcnt++;
        if (fcnt >= 9 && fcnt <= 40) tm_dio_i = chip_word[fcnt - 9];
      end
      if (!prev_clk && tm_clk && tm_dio_oe) begin
        if (cmd_n < 8) cmd_byte[cmd_n[2:0]] = tm_dio_o;
        cmd_n++;
      end
      if (scnt <= CMD_END && !tm_dio_oe) oe_bad++;
      if (scnt > CMD_END && tm_dio_oe) oe_bad++;
    end
    prev_clk = tm_clk;
  end

  // One full scan from a start pulse; pa/pb are extra start pulses while busy.
  task automatic run_scan(input logic [31:0] w, input int pa, input int pb,
                          input logic [7:0] exp_keys, input string tag);
    int done_at;
    int ndone;
    int rise_at;
    chip_word = w;
    cmd_n     = 0;
    cmd_byte  = 8'd0;
    oe_bad    = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = -1;
    ndone   = 0;
    rise_at = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, " busy@1"}, {31'd0, busy}, 32'd1);
        check({tag, " stb@1"}, {31'd0, tm_stb}, 32'd0);
      end
      if (tm_stb && rise_at < 0) rise_at = c;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      start = (c == pa) || (c == pb);
    end
    start = 1'b0;
    check({tag, " done_cycle"}, done_at, LAT);
    check({tag, " done_count"}, ndone, 32'd1);
    check({tag, " stb_rise"}, rise_at, LAT);
    check({tag, " cmd_bits"}, cmd_n, 32'd8);
    check({tag, " cmd_byte"}, {24'd0, cmd_byte}, 32'h42);
    check({tag, " oe_window"}, oe_bad, 32'd0);
    check({tag, " raw"}, raw, w);
    check({tag, " keys"}, {24'd0, keys}, {24'd0, exp_keys});
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nd;
    int nb;
    int d1;
    int d2;
    int stb_hi;
    rst      = 1'b1;
    start    = 1'b0;
    tm_dio_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst stb", {31'd0, tm_stb}, 32'd1);
    check("rst clk", {31'd0, tm_clk}, 32'd1);
    check("rst dio_o", {31'd0, tm_dio_o}, 32'd0);
    check("rst oe", {31'd0, tm_dio_oe}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst raw", raw, 32'd0);
    check("rst keys", {24'd0, keys}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_scan(WORD_A, 0, 0, EK1, "s1");
    run_scan(WORD_A, 0, 0, EK2, "s2");
    run_scan(32'h0000_0001, 5, 200, EK3, "s3");
    run_scan(32'h0000_0010, 0, 0, EK4, "s4");
    run_scan(32'h0000_0010, 0, 0, EK5, "s5");

    // Reset during READ bit 12 (low phase spans cycles 173..176).
    chip_word = 32'h1234_5678;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 175; c++) begin
      @(negedge clk);
      if (c == 175) begin
        check("mid_read clk_low", {31'd0, tm_clk}, 32'd0);
        rst   = 1'b1;
        start = 1'b1;
      end
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("mrst stb", {31'd0, tm_stb}, 32'd1);
    check("mrst clk", {31'd0, tm_clk}, 32'd1);
    check("mrst oe", {31'd0, tm_dio_oe}, 32'd0);
    check("mrst busy", {31'd0, busy}, 32'd0);
    check("mrst raw", raw, 32'd0);
    check("mrst keys", {24'd0, keys}, 32'd0);
    nd = 0;
    nb = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    check("mrst no_done", nd, 32'd0);
    check("mrst no_busy", nb, 32'd0);

    run_scan(WORD_A, 0, 0, EK6, "s6");

    // start held high: back-to-back transactions.
    chip_word = 32'h0000_0001;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    stb_hi = 0;
    for (int c = 1; c <= 720; c++) begin
      @(negedge clk);
      if (c >= LAT && c < 2 * LAT && tm_stb) stb_hi++;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) begin
          d2 = c;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b done1", d1, LAT);
    check("b2b done2", d2, 2 * LAT);
    check("b2b stb_gap", stb_hi, 32'd1);
    check("b2b idle_end", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
